arcanoid_frame_sequencer: RTL and testbench

Per-frame game-logic scheduler for the Arkanoid datapath. Detects the start of vertical blanking from the 1024x768 timing generator's vblnk output. During blanking it runs the game-update units (paddle, ball move, collision, score) one at a time through a req/ack handshake. Frame completion, overruns and hung units are reported to the top level and debug LEDs.

---
 rtl/arcanoid_frame_sequencer_if.sv | 10 +
 rtl/arcanoid_frame_sequencer.sv | 143 ++++++++++++++
 tb/tb_arcanoid_frame_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arcanoid_frame_sequencer_if.sv
// rtl/arcanoid_frame_sequencer_if.sv - req/ack handshake between the frame sequencer and the game-update units
interface arcanoid_frame_sequencer_if #(
    parameter int NUM_STEPS = 4
);
    logic [NUM_STEPS-1:0] step_req;
    logic [NUM_STEPS-1:0] step_ack;

    modport master (output step_req, input step_ack);
    modport slave  (input step_req, output step_ack);
endinterface

// File: rtl/arcanoid_frame_sequencer.sv
// rtl/arcanoid_frame_sequencer.sv - runs the game-update units one at a time during each vertical blank
module arcanoid_frame_sequencer #(
    parameter int NUM_STEPS = 4,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 16,
    localparam int STEP_W   = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
    input  logic                       pclk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       vblnk,
    input  logic                       clr_err,
    arcanoid_frame_sequencer_if.master bus,
    output logic [STEP_W-1:0]          cur_step,
    output logic                       busy,
    output logic                       frame_tick,
    output logic [CNT_W-1:0]           frame_cnt,
    output logic                       overrun,
    output logic                       timeout_err
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state, state_n;
    logic                 vblnk_d;
    logic [TO_W-1:0]      to_cnt, to_cnt_n;
    logic [STEP_W-1:0]    step_n;
    logic [NUM_STEPS-1:0] req_n;
    logic                 rise, fall, ack_cur;
    logic                 set_ovr, set_to, cnt_inc;

    assign rise    = vblnk & ~vblnk_d;
    assign fall    = ~vblnk & vblnk_d;
    assign ack_cur = bus.step_ack[cur_step];

    always_comb begin
        state_n  = state;
        step_n   = cur_step;
        to_cnt_n = to_cnt;
        set_ovr  = 1'b0;
        set_to   = 1'b0;
        cnt_inc  = 1'b0;
        case (state)
            S_IDLE: begin
                step_n   = '0;
                to_cnt_n = '0;
                if (rise && enable) begin
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                // Losing blanking beats both ack and timeout: the frame is abandoned.
                if (fall) begin
                    set_ovr  = 1'b1;
                    state_n  = S_IDLE;
                    step_n   = '0;
                    to_cnt_n = '0;
                end else if (ack_cur) begin
                    state_n = S_GAP;
                end else if (to_cnt == TO_LAST) begin
                    set_to  = 1'b1;
                    state_n = S_GAP;
                end else begin
                    to_cnt_n = to_cnt + 1'b1;
                end
            end
            S_GAP: begin
                to_cnt_n = '0;
                if (fall) begin
                    set_ovr = 1'b1;
                    state_n = S_IDLE;
                    step_n  = '0;
                end else if (cur_step == LAST_STEP) begin
                    state_n = S_DONE;
                    cnt_inc = 1'b1;
                end else begin
                    step_n  = cur_step + 1'b1;
                    state_n = S_REQ;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                step_n  = '0;
            end
            default: begin
                state_n = S_IDLE;
                step_n  = '0;
            end
        endcase
    end

    always_comb begin
        req_n = '0;
        if (state_n == S_REQ) begin
            req_n = NUM_STEPS'(1) << step_n;
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            vblnk_d      <= 1'b0;
            to_cnt       <= '0;
            cur_step     <= '0;
            bus.step_req <= '0;
            busy         <= 1'b0;
            frame_tick   <= 1'b0;
            frame_cnt    <= '0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_n;
            vblnk_d      <= vblnk;
            to_cnt       <= to_cnt_n;
            cur_step     <= step_n;
            bus.step_req <= req_n;
            busy         <= (state_n != S_IDLE);
            frame_tick   <= (state_n == S_DONE);
            frame_cnt    <= frame_cnt + CNT_W'(cnt_inc);
            // A set event in the same cycle as clr_err keeps the flag set.
            if (set_ovr) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (set_to) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arcanoid_frame_sequencer.sv
// tb/tb_arcanoid_frame_sequencer.sv - directed self-checking bench for arcanoid_frame_sequencer
module tb_arcanoid_frame_sequencer;

    localparam int N  = 4;
    localparam int TO = 255;
    localparam int CW = 4;
    localparam int NEVER = 100000;

    logic          pclk = 1'b0;
    logic          reset;
    logic          enable;
    logic          vblnk;
    logic          clr_err;
    logic [1:0]    cur_step;
    logic          busy;
    logic          frame_tick;
    logic [CW-1:0] frame_cnt;
    logic          overrun;
    logic          timeout_err;

    arcanoid_frame_sequencer_if #(.NUM_STEPS(N)) bus ();

    arcanoid_frame_sequencer #(
        .NUM_STEPS(N),
        .TIMEOUT  (TO),
        .CNT_W    (CW)
    ) dut (
        .pclk       (pclk),
        .reset      (reset),
        .enable     (enable),
        .vblnk      (vblnk),
        .clr_err    (clr_err),
        .bus        (bus),
        .cur_step   (cur_step),
        .busy       (busy),
        .frame_tick (frame_tick),
        .frame_cnt  (frame_cnt),
        .overrun    (overrun),
        .timeout_err(timeout_err)
    );

    always #5 pclk = ~pclk;

    int            checks = 0;
    int            errors = 0;
    int            ack_delay [N];
    int            age;
    logic [N-1:0]  last_req;
    logic [N-1:0]  seq_q [$];
    int            len_q [$];
    int            ticks;
    int            cur_bad;
    bit            clr_on_to;
    logic [CW-1:0] exp_cnt;

    task automatic clear_log();
        seq_q.delete();
        len_q.delete();
        ticks   = 0;
        cur_bad = 0;
    endtask

    // One pclk cycle: observe registered outputs, then drive the unit responders.
    task automatic cycle();
        @(posedge pclk);
        #1;
        if (frame_tick) ticks++;
        if (bus.step_req !== last_req) begin
            if (last_req != '0) len_q.push_back(age);
            seq_q.push_back(bus.step_req);
            age = (bus.step_req != '0) ? 1 : 0;
        end else if (bus.step_req != '0) begin
            age++;
        end
        last_req = bus.step_req;
        if (bus.step_req != '0 && bus.step_req !== (4'b0001 << cur_step)) cur_bad++;
        bus.step_ack = '0;
        clr_err = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.step_req[i]) begin
                if (age >= ack_delay[i]) bus.step_ack[i] = 1'b1;
                if (clr_on_to && age == TO) clr_err = 1'b1;
            end
        end
    endtask

    task automatic run_until_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_req(input logic [N-1:0] want, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (bus.step_req === want) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; vblnk = 1'b0; clr_err = 1'b0; bus.step_ack = '0;
        last_req = '0; age = 0; clr_on_to = 1'b0; exp_cnt = '0;
        for (int i = 0; i < N; i++) ack_delay[i] = 3;
        repeat (3) @(posedge pclk);
        #1;
        reset = 1'b0;
        cycle();
        checks++; if (bus.step_req !== 4'b0000) begin errors++; $display("FAIL reset_req got %b exp 0000", bus.step_req); end
        checks++; if (cur_step !== 2'd0) begin errors++; $display("FAIL reset_cur got %0d exp 0", cur_step); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", frame_tick); end
        checks++; if (frame_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", frame_cnt); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", overrun); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_to got %b exp 0", timeout_err); end
    endtask

    task automatic test_sequence();
        logic [N-1:0] exp_seq [8];
        bit ok;
        exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
        clear_log();
        enable = 1'b1;
        vblnk  = 1'b1;
        cycle();
        checks++; if (bus.step_req !== 4'b0001) begin errors++; $display("FAIL seq_latency got %b exp 0001", bus.step_req); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL seq_busy got %b exp 1", busy); end
        run_until_idle(100, ok);
        vblnk = 1'b0;
        cycle();
        exp_cnt = exp_cnt + 1'b1;
        checks++; if (!ok) begin errors++; $display("FAIL seq_done got timeout exp idle"); end
        checks++; if (seq_q.size() != 8) begin errors++; $display("FAIL seq_len got %0d exp 8", seq_q.size()); end
        for (int i = 0; i < 8 && i < seq_q.size(); i++) begin
            checks++; if (seq_q[i] !== exp_seq[i]) begin errors++; $display("FAIL seq_walk[%0d] got %b exp %b", i, seq_q[i], exp_seq[i]); end
        end
        for (int i = 0; i < len_q.size(); i++) begin
            checks++; if (len_q[i] != 3) begin errors++; $display("FAIL seq_hold[%0d] got %0d exp 3", i, len_q[i]); end
        end
        checks++; if (ticks != 1) begin errors++; $display("FAIL seq_ticks got %0d exp 1", ticks); end
        checks++; if (cur_bad != 0) begin errors++; $display("FAIL seq_cur_step got %0d bad exp 0", cur_bad); end
        checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL seq_cnt got %0d exp %0d", frame_cnt, exp_cnt); end
        checks++; if (overrun !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL seq_flags got %b%b exp 00", overrun, timeout_err); end
    endtask

    task automatic test_async_reset();
        bit ok;
        vblnk = 1'b1;
        cycle();
        checks++; if (bus.step_req !== 4'b0001) begin errors++; $display("FAIL arst_pre got %b exp 0001", bus.step_req); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.step_req !== 4'b0000) begin errors++; $display("FAIL arst_req got %b exp 0000", bus.step_req); end
        checks++; if (busy !== 1'b0 || frame_cnt !== 4'd0) begin errors++; $display("FAIL arst_state got busy %b cnt %0d exp 0 0", busy, frame_cnt); end
        vblnk = 1'b0;
        cycle();
        reset = 1'b0;
        last_req = '0; age = 0; exp_cnt = '0;
        clear_log();
        repeat (10) cycle();
        checks++; if (seq_q.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL arst_quiet got %0d reqs busy %b exp 0 0", seq_q.size(), busy); end
        ok = 1'b0;
    endtask

    task automatic test_timeout();
        bit ok;
        int exp_len [4];
        clear_log();
        ack_delay[2] = NEVER;
        exp_len = '{3, 3, 255, 3};
        vblnk = 1'b1;
        run_until_idle(1500, ok);
        vblnk = 1'b0;
        cycle();
        exp_cnt = exp_cnt + 1'b1;
        checks++; if (!ok) begin errors++; $display("FAIL to_done got timeout exp idle"); end
        checks++; if (len_q.size() != 4) begin errors++; $display("FAIL to_steps got %0d exp 4", len_q.size()); end
        for (int i = 0; i < 4 && i < len_q.size(); i++) begin
            checks++; if (len_q[i] != exp_len[i]) begin errors++; $display("FAIL to_hold[%0d] got %0d exp %0d", i, len_q[i], exp_len[i]); end
        end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag got %b exp 1", timeout_err); end
        checks++; if (ticks != 1 || frame_cnt !== exp_cnt) begin errors++; $display("FAIL to_frame got ticks %0d cnt %0d exp 1 %0d", ticks, frame_cnt, exp_cnt); end
        clr_err = 1'b1;
        cycle();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear got %b exp 0", timeout_err); end

        clear_log();
        ack_delay[2] = 3;
        ack_delay[1] = TO;
        vblnk = 1'b1;
        run_until_idle(1500, ok);
        vblnk = 1'b0;
        cycle();
        exp_cnt = exp_cnt + 1'b1;
        checks++; if (len_q.size() < 2 || len_q[1] != TO) begin errors++; $display("FAIL ack_at_to_hold got %0d steps exp hold 255", len_q.size()); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL ack_at_to_flag got %b exp 0", timeout_err); end
        checks++; if (ticks != 1 || frame_cnt !== exp_cnt) begin errors++; $display("FAIL ack_at_to_frame got ticks %0d cnt %0d exp 1 %0d", ticks, frame_cnt, exp_cnt); end

        clear_log();
        ack_delay[1] = 3;
        ack_delay[2] = NEVER;
        clr_on_to = 1'b1;
        vblnk = 1'b1;
        run_until_idle(1500, ok);
        vblnk = 1'b0;
        clr_on_to = 1'b0;
        cycle();
        exp_cnt = exp_cnt + 1'b1;
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL set_beats_clr got %b exp 1", timeout_err); end
        checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL set_beats_clr_cnt got %0d exp %0d", frame_cnt, exp_cnt); end
        ack_delay[2] = 3;
        clr_err = 1'b1;
        cycle();
    endtask

    task automatic test_overrun();
        bit ok;
        clear_log();
        vblnk = 1'b1;
        wait_req(4'b0010, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovr_reach got no 0010 exp 0010"); end
        vblnk = 1'b0;
        cycle();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", overrun); end
        checks++; if (bus.step_req !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL ovr_drop got %b busy %b exp 0000 0", bus.step_req, busy); end
        repeat (5) cycle();
        checks++; if (ticks != 0 || frame_cnt !== exp_cnt) begin errors++; $display("FAIL ovr_no_frame got ticks %0d cnt %0d exp 0 %0d", ticks, frame_cnt, exp_cnt); end
        vblnk = 1'b1;
        cycle();
        checks++; if (bus.step_req !== 4'b0001) begin errors++; $display("FAIL ovr_restart got %b exp 0001", bus.step_req); end
        run_until_idle(100, ok);
        vblnk = 1'b0;
        cycle();
        exp_cnt = exp_cnt + 1'b1;
        checks++; if (ticks != 1 || frame_cnt !== exp_cnt) begin errors++; $display("FAIL ovr_recover got ticks %0d cnt %0d exp 1 %0d", ticks, frame_cnt, exp_cnt); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
        clr_err = 1'b1;
        cycle();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", overrun); end
    endtask

    task automatic test_enable();
        bit ok;
        int act;
        clear_log();
        enable = 1'b0;
        vblnk  = 1'b1;
        act = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) enable = 1'b1;
            cycle();
            if (busy || bus.step_req != '0) act++;
        end
        checks++; if (act != 0) begin errors++; $display("FAIL en_gate got %0d active cycles exp 0", act); end
        vblnk = 1'b0;
        cycle();
        clear_log();
        vblnk = 1'b1;
        wait_req(4'b0010, 50, ok);
        enable = 1'b0;
        run_until_idle(100, ok);
        vblnk = 1'b0;
        cycle();
        exp_cnt = exp_cnt + 1'b1;
        checks++; if (ticks != 1 || frame_cnt !== exp_cnt) begin errors++; $display("FAIL en_midseq got ticks %0d cnt %0d exp 1 %0d", ticks, frame_cnt, exp_cnt); end
        enable = 1'b1;
    endtask

    task automatic test_wrap();
        bit ok;
        for (int f = 0; f < 12; f++) begin
            vblnk = 1'b1;
            run_until_idle(100, ok);
            vblnk = 1'b0;
            cycle();
            exp_cnt = exp_cnt + 1'b1;
            checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL wrap_cnt[%0d] got %0d exp %0d", f, frame_cnt, exp_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_async_reset();
        test_timeout();
        test_overrun();
        test_enable();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
